// File: rtl/clk_reset_sequencer_pkg.sv
// Shared types and constants for the clock/reset sequencer.
package clk_reset_sequencer_pkg;

    // Sequencer states; the encoding is visible on state_dbg.
    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_STABLE = 2'd1,
        ST_MEM    = 2'd2,
        ST_RUN    = 2'd3
    } seq_state_e;

    localparam int LOSS_CNT_W = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

    // Larger of two integers, used to size the shared phase counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clk_reset_sequencer_sync_debounce.sv
// Synchronizer chain with an optional consecutive-high debounce filter.
// With CYCLES=1 the filter is transparent and the block is a plain synchronizer.
module sync_debounce #(
    parameter int STAGES = 2,
    parameter int CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic dout_o
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic [STAGES-1:0] sync_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              din_s;

    assign din_s = sync_q[STAGES-1];

    // Shift the asynchronous input through the synchronizer and update the debounce count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples its pre-edge neighbour.
            sync_q <= {sync_q[STAGES-2:0], din_i};
            cnt_q  <= cnt_d;
        end
    end

    // Count consecutive synchronized-high cycles, holding at the last value.
    always_comb begin
        // NOTE: default assignment first, so no path leaves cnt_d unassigned (no latch).
        cnt_d = cnt_q;
        if (!din_s) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Accepted once the count has saturated and the input is still high; drops with the input.
    assign dout_o = din_s && (cnt_q == CNT_LAST);

endmodule

// File: rtl/clk_reset_sequencer.sv
// Staged reset sequencer: qualifies PLL lock, releases memory reset first and
// processor reset MEM_LEAD_CYCLES later, and re-enters reset on lock loss or button.
module clk_reset_sequencer
    import clk_reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MEM_LEAD_CYCLES     = 16,
    parameter int BTN_DEBOUNCE_CYCLES = 65536
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  btn_reset,
    output logic                  rst_mem,
    output logic                  rst_proc,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_count,
    output logic [1:0]            state_dbg
);

    localparam int CNT_W = $clog2(max_int(LOCK_STABLE_CYCLES, MEM_LEAD_CYCLES) + 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MEM_LAST    = CNT_W'(MEM_LEAD_CYCLES - 1);

    logic                  locked_s;
    logic                  btn_db;
    logic                  lock_lost;
    logic                  in_mem_run;
    seq_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LOSS_CNT_W-1:0] llc_q, llc_d;
    logic                  rst_mem_q, rst_mem_d;
    logic                  rst_proc_q, rst_proc_d;
    logic                  ready_q, ready_d;

    sync_debounce #(
        .STAGES (SYNC_STAGES),
        .CYCLES (1)
    ) u_lock_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (pll_locked),
        .dout_o (locked_s)
    );

    sync_debounce #(
        .STAGES (SYNC_STAGES),
        .CYCLES (BTN_DEBOUNCE_CYCLES)
    ) u_btn_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (btn_reset),
        .dout_o (btn_db)
    );

    assign lock_lost  = !locked_s && (state_q != ST_HOLD);
    assign in_mem_run = (state_q == ST_MEM) || (state_q == ST_RUN);

    // State, phase counter, loss counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HOLD;
            cnt_q      <= '0;
            llc_q      <= '0;
            rst_mem_q  <= 1'b1;
            rst_proc_q <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            llc_q      <= llc_d;
            rst_mem_q  <= rst_mem_d;
            rst_proc_q <= rst_proc_d;
            ready_q    <= ready_d;
        end
    end

    // Next-state logic: button and lock loss override the normal qualification walk.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        llc_d   = llc_q;

        // Only losses after memory was released are worth counting for debug.
        if (lock_lost && in_mem_run && (llc_q != LOSS_CNT_MAX)) begin
            llc_d = llc_q + LOSS_CNT_W'(1);
        end

        if (btn_db || lock_lost) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (locked_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end
                end
                ST_STABLE: begin
                    if (cnt_q == STABLE_LAST) begin
                        state_d = ST_MEM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_MEM: begin
                    if (cnt_q == MEM_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Output decode from the next state so outputs move on the same edge as the state.
    always_comb begin
        rst_mem_d  = (state_d == ST_HOLD) || (state_d == ST_STABLE);
        rst_proc_d = (state_d != ST_RUN);
        ready_d    = (state_d == ST_RUN);
    end

    assign rst_mem         = rst_mem_q;
    assign rst_proc        = rst_proc_q;
    assign ready           = ready_q;
    assign lock_loss_count = llc_q;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Self-checking bench for clk_reset_sequencer with a timeline-level reference model.
module tb_clk_reset_sequencer;

    localparam int SYNC = 2;
    localparam int LSC  = 8;
    localparam int MLC  = 4;
    localparam int BTN  = 4;
    localparam logic [12:0] RESET_VEC = 13'h1800;

    logic       clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       rst_n = 1'b1;
    logic       pll_locked = 1'b0;
    logic       btn_reset = 1'b0;
    logic       rst_mem;
    logic       rst_proc;
    logic       ready;
    logic [7:0] lock_loss_count;
    logic [1:0] state_dbg;
    logic [12:0] obs;

    int checks = 0;
    int errors = 0;

    // Reference model: pin samples delayed through queues, then the sequence is
    // described only by the edge at which qualification began.
    logic        lock_dl[$];
    logic        btn_dl[$];
    int          n;
    int          qual_start;
    int          btn_run;
    int          m_llc;
    logic [12:0] exp_vec;

    clk_reset_sequencer #(
        .SYNC_STAGES         (SYNC),
        .LOCK_STABLE_CYCLES  (LSC),
        .MEM_LEAD_CYCLES     (MLC),
        .BTN_DEBOUNCE_CYCLES (BTN)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pll_locked      (pll_locked),
        .btn_reset       (btn_reset),
        .rst_mem         (rst_mem),
        .rst_proc        (rst_proc),
        .ready           (ready),
        .lock_loss_count (lock_loss_count),
        .state_dbg       (state_dbg)
    );

    assign obs = {rst_mem, rst_proc, ready, state_dbg, lock_loss_count};

    always #5 if (clk_en) clk = ~clk;

    task automatic model_reset();
        lock_dl.delete();
        btn_dl.delete();
        for (int i = 0; i < SYNC; i++) begin
            lock_dl.push_back(1'b0);
            btn_dl.push_back(1'b0);
        end
        n          = 0;
        qual_start = -1;
        btn_run    = 0;
        m_llc      = 0;
        exp_vec    = RESET_VEC;
    endtask

    // Drive pins, take one rising edge, advance the model, return at the falling edge.
    task automatic tick(input logic pl, input logic bt);
        logic ls, bs, db, in_seq, past_mem;
        int   ph;
        logic [1:0] ps;
        logic [7:0] lc;
        pll_locked = pl;
        btn_reset  = bt;
        @(posedge clk);
        n++;
        ls = lock_dl.pop_front();
        lock_dl.push_back(pl);
        bs = btn_dl.pop_front();
        btn_dl.push_back(bt);
        btn_run  = bs ? btn_run + 1 : 0;
        db       = (btn_run >= BTN);
        in_seq   = (qual_start >= 0);
        past_mem = in_seq && ((n - 1 - qual_start) >= LSC);
        if (in_seq && !ls && past_mem && m_llc < 255) m_llc++;
        if (db || (in_seq && !ls)) qual_start = -1;
        else if (!in_seq && ls) qual_start = n;
        if (qual_start < 0) ph = 0;
        else if (n - qual_start < LSC) ph = 1;
        else if (n - qual_start < LSC + MLC) ph = 2;
        else ph = 3;
        ps = ph[1:0];
        lc = m_llc[7:0];
        exp_vec = {(ph < 2), (ph != 3), (ph == 3), ps, lc};
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        clk_en = 1'b0;
        #7 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_async: got %b expected %b", obs, RESET_VEC);
        end
        #20;
        checks++;
        if (obs !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_hold: got %b expected %b", obs, RESET_VEC);
        end
        rst_n  = 1'b1;
        clk_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL reset_unlocked edge %0d: got %b expected %b", n, obs, exp_vec);
            end
        end
    endtask

    task automatic test_powerup();
        int mem_edge = -1;
        int run_edge = -1;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL powerup edge %0d: got %b expected %b", n, obs, exp_vec);
            end
            if (mem_edge < 0 && rst_mem === 1'b0) mem_edge = n;
            if (run_edge < 0 && ready === 1'b1) run_edge = n;
        end
        checks++;
        if (mem_edge != 3 + LSC) begin
            errors++;
            $display("FAIL powerup_mem_edge: got %0d expected %0d", mem_edge, 3 + LSC);
        end
        checks++;
        if (run_edge != 3 + LSC + MLC) begin
            errors++;
            $display("FAIL powerup_run_edge: got %0d expected %0d", run_edge, 3 + LSC + MLC);
        end
    endtask

    task automatic test_lock_glitch();
        int mem_edge = -1;
        apply_reset();
        for (int i = 1; i <= 30; i++) begin
            tick((i == 6) ? 1'b0 : 1'b1, 1'b0);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL glitch edge %0d: got %b expected %b", n, obs, exp_vec);
            end
            if (mem_edge < 0 && rst_mem === 1'b0) mem_edge = n;
        end
        // Loss seen at edge 8, re-qualification starts at edge 9.
        checks++;
        if (mem_edge != 9 + LSC) begin
            errors++;
            $display("FAIL glitch_mem_edge: got %0d expected %0d", mem_edge, 9 + LSC);
        end
        checks++;
        if (lock_loss_count !== 8'd0) begin
            errors++;
            $display("FAIL glitch_loss_count: got %0d expected 0", lock_loss_count);
        end
    endtask

    task automatic test_lock_loss_run();
        logic exp_ready;
        for (int i = 1; i <= 16; i++) begin
            tick((i == 1) ? 1'b0 : 1'b1, 1'b0);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL lossrun edge %0d: got %b expected %b", n, obs, exp_vec);
            end
            if (i <= 3) begin
                exp_ready = (i < 3);
                checks++;
                if (ready !== exp_ready) begin
                    errors++;
                    $display("FAIL lossrun_ready step %0d: got %b expected %b", i, ready, exp_ready);
                end
            end
        end
        checks++;
        if (lock_loss_count !== 8'd1 || ready !== 1'b1) begin
            errors++;
            $display("FAIL lossrun_final: count %0d ready %b expected 1 1", lock_loss_count, ready);
        end
    endtask

    task automatic test_button();
        int ticks_to_run = -1;
        for (int i = 0; i < 13; i++) begin
            tick(1'b1, (i < 3) ? 1'b1 : 1'b0);
            checks++;
            if (obs !== exp_vec || ready !== 1'b1) begin
                errors++;
                $display("FAIL btn_short edge %0d: got %b expected %b", n, obs, exp_vec);
            end
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL btn_long edge %0d: got %b expected %b", n, obs, exp_vec);
            end
        end
        checks++;
        if (state_dbg !== 2'd0 || lock_loss_count !== 8'd1) begin
            errors++;
            $display("FAIL btn_hold: state %0d count %0d expected 0 1", state_dbg, lock_loss_count);
        end
        for (int i = 1; i <= 40 && ticks_to_run < 0; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL btn_release edge %0d: got %b expected %b", n, obs, exp_vec);
            end
            if (ready === 1'b1) ticks_to_run = i;
        end
        // Two synchronizer edges, then 1 + LSC + MLC edges of resequencing.
        checks++;
        if (ticks_to_run != SYNC + 1 + LSC + MLC) begin
            errors++;
            $display("FAIL btn_rerun_latency: got %0d expected %0d", ticks_to_run, SYNC + 1 + LSC + MLC);
        end
    endtask

    task automatic test_random();
        int   lock_rem = 0;
        int   btn_rem = 0;
        logic pl = 1'b1;
        logic bt = 1'b0;
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            if (lock_rem == 0) begin
                pl = ($urandom_range(9, 0) < 8);
                lock_rem = pl ? $urandom_range(40, 1) : $urandom_range(4, 1);
            end
            if (btn_rem == 0) begin
                bt = ~bt & ($urandom_range(3, 0) == 0);
                btn_rem = bt ? $urandom_range(8, 1) : $urandom_range(60, 5);
            end
            lock_rem--;
            btn_rem--;
            tick(pl, bt);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL random edge %0d: got %b expected %b", n, obs, exp_vec);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 15; i++) begin
                tick((i == 0) ? 1'b0 : 1'b1, 1'b0);
                checks++;
                if (obs !== exp_vec) begin
                    errors++;
                    $display("FAIL saturate loss %0d edge %0d: got %b expected %b", k, n, obs, exp_vec);
                end
            end
        end
        checks++;
        if (lock_loss_count !== 8'd255) begin
            errors++;
            $display("FAIL saturate_final: got %0d expected 255", lock_loss_count);
        end
    endtask

    task automatic test_rst_in_mem();
        int mem_edge = -1;
        int run_edge = -1;
        bit reached = 0;
        apply_reset();
        for (int i = 0; i < 30 && !reached; i++) begin
            tick(1'b1, 1'b0);
            if (state_dbg === 2'd2) reached = 1;
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL rstmem_reach: state %0d expected 2 within 30 edges", state_dbg);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs !== RESET_VEC) begin
            errors++;
            $display("FAIL rstmem_async: got %b expected %b", obs, RESET_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (obs !== exp_vec) begin
                errors++;
                $display("FAIL rstmem_reseq edge %0d: got %b expected %b", n, obs, exp_vec);
            end
            if (mem_edge < 0 && rst_mem === 1'b0) mem_edge = n;
            if (run_edge < 0 && ready === 1'b1) run_edge = n;
        end
        checks++;
        if (mem_edge != 3 + LSC || run_edge != 3 + LSC + MLC) begin
            errors++;
            $display("FAIL rstmem_edges: got %0d/%0d expected %0d/%0d", mem_edge, run_edge, 3 + LSC, 3 + LSC + MLC);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_powerup();
        test_lock_glitch();
        test_lock_loss_run();
        test_button();
        test_random();
        test_saturation();
        test_rst_in_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
